// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter for the single register-file write port.
// One holding buffer per source, round-robin grant, same-register writes kept in acceptance order.
module rf_write_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_id,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_id,
    input  logic [DATA_W-1:0] req1_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_id,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_id_a,
    input  logic [ADDR_W-1:0] rd_id_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              busy
);

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_id [2];
    logic [DATA_W-1:0] req_data [2];

    logic [1:0]        hold_v_reg;
    logic [ADDR_W-1:0] hold_id_reg [2];
    logic [DATA_W-1:0] hold_data_reg [2];
    logic              rr_reg;
    logic              older_reg;

    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] accept;
    logic [1:0] remain;
    logic [1:0] match_a;
    logic [1:0] match_b;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_id[0]   = req0_id;
    assign req_id[1]   = req1_id;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Grant is suppressed during reset so that in-flight holds are never written.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            unique case (hold_v_reg)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    if (hold_id_reg[0] != hold_id_reg[1])
                        grant = rr_reg ? 2'b10 : 2'b01;
                    else
                        grant = older_reg ? 2'b10 : 2'b01;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hold
            assign ready[gi]   = ~rst & (~hold_v_reg[gi] | grant[gi]);
            assign accept[gi]  = req_valid[gi] & ready[gi];
            assign remain[gi]  = hold_v_reg[gi] & ~grant[gi];
            assign match_a[gi] = hold_v_reg[gi] & (hold_id_reg[gi] == rd_id_a);
            assign match_b[gi] = hold_v_reg[gi] & (hold_id_reg[gi] == rd_id_b);

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_v_reg[gi] <= 1'b0;
                end else if (accept[gi]) begin
                    // Writes to R0 complete the handshake but never occupy the buffer.
                    hold_v_reg[gi]    <= !(DROP_R0 && (req_id[gi] == '0));
                    hold_id_reg[gi]   <= req_id[gi];
                    hold_data_reg[gi] <= req_data[gi];
                end else if (grant[gi]) begin
                    hold_v_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg    <= 1'b0;
            older_reg <= 1'b0;
        end else begin
            if (|grant)
                rr_reg <= grant[0];
            // Simultaneous acceptance ties go to the load source as the older entry.
            if (&accept)
                older_reg <= 1'b1;
            else if (accept[0])
                older_reg <= remain[1];
            else if (accept[1])
                older_reg <= ~remain[0];
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign wr_en      = |grant;
    assign wr_id      = grant[1] ? hold_id_reg[1]   : (grant[0] ? hold_id_reg[0]   : '0);
    assign wr_data    = grant[1] ? hold_data_reg[1] : (grant[0] ? hold_data_reg[0] : '0);
    assign hazard_a   = |match_a;
    assign hazard_b   = |match_b;
    assign busy       = |hold_v_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a transaction-level model predicts writes into a queue,
// a monitor pops and compares every write the DUT issues; a register-file image is compared at the end.
module tb_rf_write_arbiter;

    localparam bit DROP = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_id, req1_id, rd_id_a, rd_id_b, wr_id;
    logic [15:0] req0_data, req1_data, wr_data;
    logic        wr_en, hazard_a, hazard_b, busy;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q [$];
    logic [15:0] rf_model [16];
    logic [15:0] rf_dut [16];

    // Model state: pending entries tagged with an age key (smaller = accepted earlier).
    bit          pv [2];
    logic [3:0]  pid [2];
    logic [15:0] pdata [2];
    longint      pkey [2];
    int          rr_m = 0;
    longint      cyc = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(16), .ADDR_W(4), .DROP_R0(DROP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_id(req0_id), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_id(req1_id), .req1_data(req1_data),
        .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
        .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: evaluated mid-cycle with the inputs that will be sampled at the next edge.
    always @(negedge clk) begin
        int  g;
        bit  er [2];
        bit  vin [2];
        logic [3:0]  iin [2];
        logic [15:0] din [2];
        vin[0] = req0_valid; iin[0] = req0_id; din[0] = req0_data;
        vin[1] = req1_valid; iin[1] = req1_id; din[1] = req1_data;
        g = -1;
        if (!rst) begin
            if (pv[0] && !pv[1]) g = 0;
            else if (pv[1] && !pv[0]) g = 1;
            else if (pv[0] && pv[1]) g = (pid[0] != pid[1]) ? rr_m : ((pkey[0] < pkey[1]) ? 0 : 1);
        end
        for (int i = 0; i < 2; i++) er[i] = !rst && (!pv[i] || g == i);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, er[0]});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, er[1]});
        chk("busy", {31'd0, busy}, {31'd0, pv[0] | pv[1]});
        chk("hazard_a", {31'd0, hazard_a},
            {31'd0, (pv[0] && pid[0] == rd_id_a) || (pv[1] && pid[1] == rd_id_a)});
        chk("hazard_b", {31'd0, hazard_b},
            {31'd0, (pv[0] && pid[0] == rd_id_b) || (pv[1] && pid[1] == rd_id_b)});
        chk("wr_en", {31'd0, wr_en}, {31'd0, g >= 0});
        if (g >= 0) begin
            exp_q.push_back({pid[g], pdata[g]});
            rf_model[pid[g]] = pdata[g];
        end else begin
            chk("idle_wr_bus", {12'd0, wr_id, wr_data}, 32'd0);
        end
        if (rst) begin
            pv[0] = 0; pv[1] = 0; rr_m = 0;
        end else begin
            if (g >= 0) begin
                pv[g] = 0;
                rr_m = 1 - g;
            end
            for (int i = 0; i < 2; i++) begin
                if (vin[i] && er[i] && !(DROP && iin[i] == 4'd0)) begin
                    pv[i] = 1; pid[i] = iin[i]; pdata[i] = din[i];
                    pkey[i] = cyc * 2 + ((i == 0) ? 1 : 0);
                end
            end
        end
        cyc++;
    end

    // Monitor: every DUT write must match the oldest predicted write.
    always @(negedge clk) begin
        logic [19:0] e;
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write at cycle %0d: got id %h data %h expected no write",
                         cyc, wr_id, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_id", {28'd0, wr_id}, {28'd0, e[19:16]});
                chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
            end
            rf_dut[wr_id] = wr_data;
        end
    end

    task automatic drive(input logic v0, input logic [3:0] i0, input logic [15:0] d0,
                         input logic v1, input logic [3:0] i1, input logic [15:0] d1,
                         input logic [3:0] ra, input logic [3:0] rb, input logic r);
        req0_valid = v0; req0_id = i0; req0_data = d0;
        req1_valid = v1; req1_id = i1; req1_data = d1;
        rd_id_a = ra; rd_id_b = rb; rst = r;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [3:0] ra);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, ra, 4'd0, 0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin rf_model[k] = 16'd0; rf_dut[k] = 16'd0; end
        pv[0] = 0; pv[1] = 0;
        rst = 1; req0_valid = 0; req1_valid = 0; req0_id = 0; req1_id = 0;
        req0_data = 0; req1_data = 0; rd_id_a = 0; rd_id_b = 0;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 4'd3, 4'd0, 1);
        // Single ALU write with hazard lookup on the same register.
        drive(1, 4'd3, 16'h1234, 0, 0, 0, 4'd3, 4'd5, 0);
        idle(2, 4'd3);
        // Both sources held valid with different registers: alternating grants.
        for (int k = 0; k < 5; k++) drive(1, 4'd4, 16'hAAAA, 1, 4'd5, 16'h5555, 4'd4, 4'd5, 0);
        idle(3, 4'd4);
        // Same-register collision: load is older, ALU value survives.
        drive(1, 4'd7, 16'h0001, 1, 4'd7, 16'h0002, 4'd7, 4'd7, 0);
        idle(3, 4'd7);
        // Write to R0 is swallowed.
        drive(1, 4'd0, 16'hFFFF, 0, 0, 0, 4'd0, 4'd0, 0);
        idle(2, 4'd0);
        // Pending load dropped by reset.
        drive(0, 0, 0, 1, 4'd9, 16'hBEEF, 4'd9, 4'd0, 0);
        drive(1, 4'd10, 16'h0BAD, 1, 4'd11, 16'hDEAD, 4'd9, 4'd0, 1);
        idle(3, 4'd9);
        // Back-to-back ALU writes, one per cycle.
        for (int k = 1; k <= 8; k++) drive(1, k[3:0], 16'h0100 + k[15:0], 0, 0, 0, k[3:0], 4'd0, 0);
        idle(3, 4'd1);
        // Randomized traffic with narrow id range to provoke same-register collisions.
        for (int k = 0; k < 1500; k++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 4)), 16'($urandom),
                  $urandom_range(0, 2) != 0, 4'($urandom_range(0, 4)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)),
                  $urandom_range(0, 63) == 0);
        end
        idle(4, 4'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        for (int k = 0; k < 16; k++) chk($sformatf("rf_reg%0d", k), {16'd0, rf_dut[k]}, {16'd0, rf_model[k]});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
